fir_filter_systolic: RTL and testbench

FIR_FILTER_SYSTOLIC -- requirements
Module: fir_filter_systolic

---
 rtl/fir_filter_systolic.sv | 186 ++++++++++++++++++
 tb/tb_fir_filter_systolic.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_systolic.sv
// Transposed-form systolic FIR: serial coefficient load, three-stage sample pipeline,
// round-half-up output scaling with signed saturation.
module fir_filter_systolic #(
    parameter int X_N_WIDTH = 20,
    parameter int H_N_WIDTH = 18,
    parameter int NUM_TAPS  = 8,
    parameter int OUT_WIDTH = 24,
    parameter int OUT_SHIFT = 14
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        coef_load_start,
    input  logic                        h_n_in_vld,
    input  logic signed [H_N_WIDTH-1:0] h_n_in,
    output logic                        coef_ready,
    input  logic                        x_n_in_vld,
    input  logic signed [X_N_WIDTH-1:0] x_n_in,
    output logic                        y_n_out_vld,
    output logic signed [OUT_WIDTH-1:0] y_n_out,
    output logic                        y_sat
);
    localparam int ACC_WIDTH = X_N_WIDTH + H_N_WIDTH + $clog2(NUM_TAPS);
    localparam int PRD_WIDTH = X_N_WIDTH + H_N_WIDTH;
    localparam int CNT_WIDTH = $clog2(NUM_TAPS);
    localparam int RND_POS   = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic [CNT_WIDTH-1:0]    CNT_LAST = CNT_WIDTH'(NUM_TAPS - 1);
    localparam logic signed [ACC_WIDTH:0] RND_C  = (OUT_SHIFT > 0) ?
        ({{ACC_WIDTH{1'b0}}, 1'b1} << RND_POS) : {(ACC_WIDTH+1){1'b0}};
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN =
        {{(ACC_WIDTH+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    logic [1:0]                  r_rst_sync;
    logic                        w_rst_n;
    state_t                      r_state;
    logic [CNT_WIDTH-1:0]        r_load_cnt;
    logic                        r_coef_ready;
    logic signed [H_N_WIDTH-1:0] r_h   [NUM_TAPS];
    logic signed [X_N_WIDTH-1:0] r_x;
    logic signed [PRD_WIDTH-1:0] r_p   [NUM_TAPS];
    logic signed [ACC_WIDTH-1:0] r_acc [1:NUM_TAPS-1];
    logic                        r_v1;
    logic                        r_v2;
    logic                        r_y_vld;
    logic signed [OUT_WIDTH-1:0] r_y;
    logic                        r_y_sat;
    logic                        w_x_accept;
    logic                        w_y_take;
    logic signed [ACC_WIDTH-1:0] w_acc0_next;
    logic signed [OUT_WIDTH-1:0] w_y;
    logic                        w_sat;

    // Round half up, arithmetic shift, clip to the signed output range; returns {sat, y}.
    function automatic logic [OUT_WIDTH:0] round_sat(input logic signed [ACC_WIDTH-1:0] acc);
        logic signed [ACC_WIDTH:0]   rounded;
        logic signed [ACC_WIDTH:0]   shifted;
        logic                        sat;
        logic signed [OUT_WIDTH-1:0] y;
        rounded = {acc[ACC_WIDTH-1], acc} + RND_C;
        shifted = rounded >>> OUT_SHIFT;
        if (shifted > SAT_MAX) begin
            sat = 1'b1;
            y   = SAT_MAX[OUT_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            sat = 1'b1;
            y   = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            sat = 1'b0;
            y   = shifted[OUT_WIDTH-1:0];
        end
        return {sat, y};
    endfunction

    assign w_rst_n     = r_rst_sync[1];
    assign w_x_accept  = x_n_in_vld && (r_state == ST_RUN) && !coef_load_start;
    assign w_y_take    = r_v2 && !coef_load_start;
    assign w_acc0_next = r_acc[1] + ACC_WIDTH'(r_p[0]);
    assign {w_sat, w_y} = round_sat(w_acc0_next);

    assign coef_ready  = r_coef_ready;
    assign y_n_out_vld = r_y_vld;
    assign y_n_out     = r_y;
    assign y_sat       = r_y_sat;

    // Reset synchroniser: asserts immediately, releases two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    // Control FSM and coefficient shift register; a load request overrides everything.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= ST_EMPTY;
            r_load_cnt   <= '0;
            r_coef_ready <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) r_h[k] <= '0;
        end else if (coef_load_start) begin
            r_state      <= ST_LOADING;
            r_load_cnt   <= '0;
            r_coef_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    r_coef_ready <= 1'b0;
                end
                ST_LOADING: begin
                    if (h_n_in_vld) begin
                        for (int k = 0; k < NUM_TAPS - 1; k++) r_h[k] <= r_h[k+1];
                        r_h[NUM_TAPS-1] <= h_n_in;
                        if (r_load_cnt == CNT_LAST) begin
                            r_state      <= ST_RUN;
                            r_load_cnt   <= '0;
                            r_coef_ready <= 1'b1;
                        end else begin
                            r_load_cnt   <= r_load_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                ST_RUN: begin
                    r_coef_ready <= 1'b1;
                end
                default: begin
                    r_state      <= ST_EMPTY;
                    r_load_cnt   <= '0;
                    r_coef_ready <= 1'b0;
                end
            endcase
        end
    end

    // Sample, product and transposed accumulator stages, each gated by its own valid.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_x  <= '0;
            for (int k = 0; k < NUM_TAPS; k++) r_p[k] <= '0;
            for (int k = 1; k < NUM_TAPS; k++) r_acc[k] <= '0;
        end else if (coef_load_start) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            for (int k = 1; k < NUM_TAPS; k++) r_acc[k] <= '0;
        end else begin
            r_v1 <= w_x_accept;
            r_v2 <= r_v1;
            if (w_x_accept) begin
                r_x <= x_n_in;
            end
            if (r_v1) begin
                for (int k = 0; k < NUM_TAPS; k++)
                    r_p[k] <= PRD_WIDTH'(r_x) * PRD_WIDTH'(r_h[k]);
            end
            if (r_v2) begin
                for (int k = 1; k < NUM_TAPS - 1; k++)
                    r_acc[k] <= r_acc[k+1] + ACC_WIDTH'(r_p[k]);
                r_acc[NUM_TAPS-1] <= ACC_WIDTH'(r_p[NUM_TAPS-1]);
            end
        end
    end

    // acc[0] is never stored: its next value is scaled straight into the output register.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_y_vld <= 1'b0;
            r_y     <= '0;
            r_y_sat <= 1'b0;
        end else begin
            r_y_vld <= w_y_take;
            if (w_y_take) begin
                r_y     <= w_y;
                r_y_sat <= w_sat;
            end
        end
    end
endmodule

// File: tb/tb_fir_filter_systolic.sv
// Directed bench: a 4-tap unscaled instance for control/filter behaviour and a
// default-parameter instance for rounding and saturation.
`timescale 1ns/100ps
module tb_fir_filter_systolic;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                s_load, s_hvld, s_xvld, s_ready, s_yvld, s_sat;
    logic signed [17:0]  s_h;
    logic signed [19:0]  s_x;
    logic signed [23:0]  s_y;
    logic                b_load, b_hvld, b_xvld, b_ready, b_yvld, b_sat;
    logic signed [17:0]  b_h;
    logic signed [19:0]  b_x;
    logic signed [23:0]  b_y;

    int checks   = 0;
    int failures = 0;

    logic               sv_vld [0:31];
    logic signed [19:0] sv_x   [0:31];
    int                 exp_y  [0:31];

    fir_filter_systolic #(.X_N_WIDTH(20), .H_N_WIDTH(18), .NUM_TAPS(4),
                          .OUT_WIDTH(24), .OUT_SHIFT(0)) u_small (
        .clk(clk), .rst_n(rst_n), .coef_load_start(s_load), .h_n_in_vld(s_hvld),
        .h_n_in(s_h), .coef_ready(s_ready), .x_n_in_vld(s_xvld), .x_n_in(s_x),
        .y_n_out_vld(s_yvld), .y_n_out(s_y), .y_sat(s_sat));

    fir_filter_systolic u_big (
        .clk(clk), .rst_n(rst_n), .coef_load_start(b_load), .h_n_in_vld(b_hvld),
        .h_n_in(b_h), .coef_ready(b_ready), .x_n_in_vld(b_xvld), .x_n_in(b_x),
        .y_n_out_vld(b_yvld), .y_n_out(b_y), .y_sat(b_sat));

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic hvld, input logic signed [17:0] h);
        s_load = 1'b1; s_hvld = hvld; s_h = h;
        tick();
        s_load = 1'b0; s_hvld = 1'b0;
    endtask

    task automatic load_words(input string tag, input int w0, input int w1,
                              input int w2, input int w3);
        int w [4];
        w = '{w0, w1, w2, w3};
        for (int i = 0; i < 4; i++) begin
            s_hvld = 1'b1; s_h = 18'(w[i]);
            tick();
            check({tag, "_ready"}, s_ready, (i == 3) ? 1 : 0);
        end
        s_hvld = 1'b0;
    endtask

    // Output of sample src is expected exactly after the third edge following its drive.
    task automatic run_seq(input string tag, input int ncyc);
        int src;
        int last_exp;
        bit have_last;
        have_last = 1'b0;
        last_exp  = 0;
        for (int c = 0; c < ncyc + 3; c++) begin
            if (c < ncyc) begin
                s_xvld = sv_vld[c]; s_x = sv_x[c];
            end else begin
                s_xvld = 1'b0; s_x = 20'sd0;
            end
            tick();
            src = c - 2;
            if (src >= 0 && src < ncyc && sv_vld[src]) begin
                check({tag, "_vld"}, s_yvld, 1);
                check({tag, "_y"}, s_y, exp_y[src]);
                check({tag, "_sat"}, s_sat, 0);
                last_exp  = exp_y[src];
                have_last = 1'b1;
            end else begin
                check({tag, "_novld"}, s_yvld, 0);
                if (have_last) check({tag, "_hold"}, s_y, last_exp);
            end
        end
    endtask

    task automatic impulse(input string tag, input int e0, input int e1,
                           input int e2, input int e3);
        for (int i = 0; i < 5; i++) begin
            sv_vld[i] = 1'b1;
            sv_x[i]   = (i == 0) ? 20'sd1 : 20'sd0;
        end
        exp_y[0] = e0; exp_y[1] = e1; exp_y[2] = e2; exp_y[3] = e3; exp_y[4] = 0;
        run_seq(tag, 5);
    endtask

    task automatic big_load();
        b_load = 1'b1;
        tick();
        b_load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b_hvld = 1'b1; b_h = 18'sd131071;
            tick();
        end
        b_hvld = 1'b0;
        check("big_ready", b_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        s_load = 1'b0; s_hvld = 1'b0; s_h = 18'sd0; s_xvld = 1'b0; s_x = 20'sd0;
        b_load = 1'b0; b_hvld = 1'b0; b_h = 18'sd0; b_xvld = 1'b0; b_x = 20'sd0;
        repeat (3) tick();
        check("rst_y", s_y, 0);
        check("rst_vld", s_yvld, 0);
        check("rst_sat", s_sat, 0);
        check("rst_ready", s_ready, 0);
        check("rst_big_y", b_y, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // EMPTY ignores samples and coefficient words.
        s_xvld = 1'b1; s_x = 20'sd5; s_hvld = 1'b1; s_h = 18'sd7;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("empty_novld", s_yvld, 0);
            check("empty_ready", s_ready, 0);
        end
        s_xvld = 1'b0; s_hvld = 1'b0;

        // Word coincident with the load pulse is discarded.
        pulse_load(1'b1, 18'sd99);
        check("load_ready0", s_ready, 0);
        load_words("load1", 1, 2, 3, 4);
        impulse("imp1", 1, 2, 3, 4);

        // Coefficient words in RUN are ignored.
        s_hvld = 1'b1; s_h = 18'sd50;
        tick();
        s_hvld = 1'b0;
        check("run_hvld_ready", s_ready, 1);

        for (int i = 0; i < 15; i++) begin
            sv_vld[i] = (i % 3 == 0);
            sv_x[i]   = (i % 3 == 0) ? 20'sd1 : 20'sd9;
        end
        exp_y[0] = 1; exp_y[3] = 3; exp_y[6] = 6; exp_y[9] = 10; exp_y[12] = 10;
        run_seq("gap_step", 15);

        pulse_load(1'b0, 18'sd0);
        load_words("load2", 1, 2, 3, 4);
        for (int i = 0; i < 5; i++) begin
            sv_vld[i] = 1'b1; sv_x[i] = 20'sd1;
        end
        exp_y[0] = 1; exp_y[1] = 3; exp_y[2] = 6; exp_y[3] = 10; exp_y[4] = 10;
        run_seq("step", 5);

        // Reload with two samples in flight: neither may emerge.
        s_xvld = 1'b1; s_x = 20'sd5;
        tick();
        s_x = 20'sd6;
        tick();
        s_xvld = 1'b0; s_load = 1'b1;
        tick();
        s_load = 1'b0;
        check("flush_vld0", s_yvld, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_vld", s_yvld, 0);
        end
        load_words("load3", 2, -1, 0, 3);
        impulse("imp2", 2, -1, 0, 3);

        // Default-parameter instance: rounding and both saturation rails.
        big_load();
        for (int c = 0; c < 10; c++) begin
            b_xvld = (c < 8); b_x = 20'sd524287;
            tick();
            if (c == 2) begin
                check("big_y0", b_y, 4194264);
                check("big_sat0", b_sat, 0);
            end
            if (c == 3) begin
                check("big_y1", b_y, 8388528);
                check("big_sat1", b_sat, 0);
            end
            if (c == 9) begin
                check("big_vld7", b_yvld, 1);
                check("big_ymax", b_y, 8388607);
                check("big_satmax", b_sat, 1);
            end
        end
        b_xvld = 1'b0;
        big_load();
        for (int c = 0; c < 5; c++) begin
            b_xvld = (c < 3); b_x = 20'h80000;
            tick();
            if (c == 2) check("big_yneg", b_y, -4194272);
            if (c == 4) begin
                check("big_ymin", b_y, -8388608);
                check("big_satmin", b_sat, 1);
            end
        end
        b_xvld = 1'b0;

        // Short off-edge reset pulse mid-stream.
        s_xvld = 1'b1; s_x = 20'sd1;
        repeat (4) tick();
        check("pre_rst_vld", s_yvld, 1);
        #2;
        rst_n = 1'b0;
        #0.5;
        check("arst_y", s_y, 0);
        check("arst_vld", s_yvld, 0);
        check("arst_sat", s_sat, 0);
        check("arst_ready", s_ready, 0);
        #0.5;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_novld", s_yvld, 0);
            check("post_rst_ready", s_ready, 0);
        end
        s_xvld = 1'b0;
        pulse_load(1'b0, 18'sd0);
        load_words("load4", 1, 2, 3, 4);
        impulse("imp3", 1, 2, 3, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
